// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared states, stream indices and region sizing for the ROM loader
package rom_load_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_HOLD} state_t;
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;
    localparam int N_REGIONS = 4;
    localparam int REGION_W = $clog2(N_REGIONS);
endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: maps a download byte address to {valid, region, offset}
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter logic [24:0] BASE1 = 25'h0C000,
    parameter logic [24:0] BASE2 = 25'h0D000,
    parameter logic [24:0] BASE3 = 25'h15000,
    parameter logic [24:0] TOTAL = 25'h1D000
) (
    input  logic [24:0]         addr,
    output logic                valid,
    output logic [REGION_W-1:0] region,
    output logic [15:0]         offset
);
    logic [24:0] base;
    assign valid  = addr < TOTAL;
    assign region = addr >= BASE3 ? 2'd3 : addr >= BASE2 ? 2'd2 : addr >= BASE1 ? 2'd1 : 2'd0;
    assign base   = addr >= BASE3 ? BASE3 : addr >= BASE2 ? BASE2 : addr >= BASE1 ? BASE1 : 25'd0;
    assign offset = 16'(addr - base);
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers the hps_io download stream into ROM regions and config registers
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [24:0] BASE1 = 25'h0C000,
    parameter logic [24:0] BASE2 = 25'h0D000,
    parameter logic [24:0] BASE3 = 25'h15000,
    parameter logic [24:0] TOTAL = 25'h1D000,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic                ioctl_wait,
    input  logic                tgt_ready,
    output logic                rom_wr,
    output logic [REGION_W-1:0] rom_region,
    output logic [15:0]         rom_addr,
    output logic [7:0]          rom_data,
    output logic                core_reset_hold,
    output logic [7:0]          mod,
    output logic [63:0]         dip,
    output logic                overrun
);
    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    state_t state;
    logic [CW-1:0] hold_cnt;
    logic dec_valid;
    logic [REGION_W-1:0] dec_region;
    logic [15:0] dec_offset;
    logic rom_strobe, dl_start;
    assign rom_strobe = ioctl_wr && ioctl_index == IDX_ROM;
    assign dl_start   = ioctl_download && ioctl_index == IDX_ROM;
    rom_region_decode #(.BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3), .TOTAL(TOTAL)) u_dec (
        .addr   (ioctl_addr),
        .valid  (dec_valid),
        .region (dec_region),
        .offset (dec_offset)
    );
    // Region bases must ascend and no region may exceed the 16-bit offset range.
    assert property (@(posedge clk_sys) BASE1 < BASE2 && BASE2 < BASE3 && BASE3 < TOTAL &&
        BASE1 <= 25'h10000 && BASE2 - BASE1 <= 25'h10000 &&
        BASE3 - BASE2 <= 25'h10000 && TOTAL - BASE3 <= 25'h10000);
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= S_IDLE;
            hold_cnt        <= '0;
            ioctl_wait      <= 1'b0;
            rom_wr          <= 1'b0;
            rom_region      <= '0;
            rom_addr        <= '0;
            rom_data        <= '0;
            core_reset_hold <= 1'b0;
            mod             <= 8'hFF;
            dip             <= '0;
            overrun         <= 1'b0;
        end else begin
            rom_wr <= 1'b0;
            if (ioctl_wr && ioctl_index == IDX_MOD) mod <= ioctl_dout;
            if (ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
                dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            case (state)
                S_IDLE: if (dl_start) begin
                    state           <= S_LOAD;
                    core_reset_hold <= 1'b1;
                end
                S_LOAD: if (!ioctl_download) begin
                    state    <= S_HOLD;
                    hold_cnt <= '0;
                end else if (rom_strobe) begin
                    if (dec_valid) begin
                        rom_region <= dec_region;
                        rom_addr   <= dec_offset;
                        rom_data   <= ioctl_dout;
                        ioctl_wait <= 1'b1;
                        state      <= S_WRITE;
                    end else overrun <= 1'b1;
                end
                S_WRITE: begin
                    if (rom_strobe) overrun <= 1'b1;
                    if (tgt_ready) begin
                        rom_wr     <= 1'b1;
                        ioctl_wait <= 1'b0;
                        hold_cnt   <= '0;
                        state      <= ioctl_download ? S_LOAD : S_HOLD;
                    end
                end
                S_HOLD: if (dl_start) state <= S_LOAD;
                else if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
                    state           <= S_IDLE;
                    core_reset_hold <= 1'b0;
                end else hold_cnt <= hold_cnt + 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: scoreboard bench comparing ROM writes and config state to a reference model
module tb_rom_load_ctrl;
    localparam logic [24:0] B1 = 25'h0C000, B2 = 25'h0D000, B3 = 25'h15000, TOT = 25'h1D000;
    localparam int HC = 16;
    logic clk_sys = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0, tgt_ready = 0;
    logic [24:0] ioctl_addr = 0;
    logic [7:0] ioctl_dout = 0, ioctl_index = 0;
    logic ioctl_wait, rom_wr, core_reset_hold, overrun;
    logic [1:0] rom_region;
    logic [15:0] rom_addr;
    logic [7:0] rom_data, mod;
    logic [63:0] dip;
    typedef struct packed {logic [1:0] region; logic [15:0] addr; logic [7:0] data;} wr_t;
    wr_t exp_q[$];
    int checks = 0, errors = 0, pushed = 0, seen = 0;
    logic exp_ovr = 0;
    logic [7:0] exp_mod = 8'hFF;
    logic [63:0] exp_dip = 0;

    rom_load_ctrl #(.BASE1(B1), .BASE2(B2), .BASE3(B3), .TOTAL(TOT), .HOLD_CYCLES(HC)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .tgt_ready(tgt_ready), .rom_wr(rom_wr), .rom_region(rom_region),
        .rom_addr(rom_addr), .rom_data(rom_data), .core_reset_hold(core_reset_hold),
        .mod(mod), .dip(dip), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin : monitor
        wr_t e;
        if (rom_wr === 1'b1) begin
            seen++;
            if (exp_q.size() == 0) check("unexpected_rom_wr", 64'(rom_wr), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("rom_write", 64'({rom_region, rom_addr, rom_data}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input int stall, input bit inject);
        logic [24:0] bases [4];
        int r, n;
        wr_t e;
        bit valid;
        bases = '{25'd0, B1, B2, B3};
        r = 0;
        for (int i = 0; i < 4; i++) if (a >= bases[i]) r = i;
        valid = a < TOT;
        if (valid) begin
            e.region = 2'(r);
            e.addr = 16'(a - bases[r]);
            e.data = d;
            exp_q.push_back(e);
            pushed++;
        end else exp_ovr = 1;
        if (inject) exp_ovr = 1;
        tgt_ready = 0;
        ioctl_index = 0;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        if (!valid) begin
            check("invalid_no_wait", 64'(ioctl_wait), 64'd0);
            check("overrun_invalid", 64'(overrun), 64'(exp_ovr));
            return;
        end
        n = 0;
        while (ioctl_wait === 1'b1 && n < 64) begin
            n++;
            tgt_ready = n > stall;
            ioctl_wr = inject && n == 2;
            if (ioctl_wr) begin
                ioctl_addr = 25'h00010;
                ioctl_dout = ~d;
            end
            tick();
        end
        ioctl_wr = 0;
        check("wait_cycles", 64'(n), 64'(stall + 1));
        check("overrun", 64'(overrun), 64'(exp_ovr));
    endtask

    task automatic cfg(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1;
        if (idx == 8'd1) exp_mod = d;
        if (idx == 8'd254 && a < 8) exp_dip[8 * int'(a) +: 8] = d;
        tick();
        ioctl_wr = 0;
        check("cfg_no_hold", 64'(core_reset_hold), 64'd0);
    endtask

    task automatic hold_phase();
        int n;
        ioctl_download = 0;
        tick();
        n = 0;
        while (core_reset_hold === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("hold_len", 64'(n), 64'(HC));
    endtask

    initial begin
        repeat (3) tick();
        reset = 0;
        tick();
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_hold", 64'(core_reset_hold), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        check("rst_mod", 64'(mod), 64'hFF);
        check("rst_dip", dip, 64'd0);
        check("rst_rom", 64'({rom_wr, rom_region, rom_addr, rom_data}), 64'd0);

        ioctl_index = 0;
        ioctl_download = 1;
        tick();
        check("hold_rise", 64'(core_reset_hold), 64'd1);
        rom_byte(25'h00000, 8'($urandom), 0, 0);
        rom_byte(25'h0C000, 8'($urandom), 0, 0);
        rom_byte(25'h0D000, 8'($urandom), 0, 0);
        rom_byte(25'h15000, 8'($urandom), 0, 0);
        rom_byte(25'h0D123, 8'hA5, 5, 0);
        for (int i = 0; i < 16; i++)
            rom_byte(25'($urandom_range(0, int'(TOT) - 1)), 8'($urandom), int'($urandom_range(0, 3)), 0);
        hold_phase();
        check("writes_done", 64'(seen), 64'(pushed));

        ioctl_index = 1;
        ioctl_download = 1;
        cfg(8'd1, 25'd0, 8'h04);
        check("mod", 64'(mod), 64'(exp_mod));
        for (int i = 0; i < 8; i++) cfg(8'd254, 25'(i), 8'(8'h11 + i));
        check("dip_seq", dip, 64'h1817161514131211);
        for (int i = 0; i < 10; i++)
            cfg(8'($urandom_range(0, 1) ? 254 : 7), 25'($urandom_range(0, 11)), 8'($urandom));
        cfg(8'd254, 25'h00100, 8'hEE);
        check("dip_rand", dip, exp_dip);
        check("mod_final", 64'(mod), 64'(exp_mod));
        ioctl_download = 0;
        ioctl_index = 0;
        tick();

        ioctl_download = 1;
        tick();
        tick();
        rom_byte(TOT, 8'h5A, 0, 0);
        rom_byte(25'($urandom_range(0, int'(TOT) - 1)), 8'($urandom), 1, 0);

        tgt_ready = 0;
        ioctl_addr = 25'h00100;
        ioctl_dout = 8'h77;
        ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        check("pending_wait", 64'(ioctl_wait), 64'd1);
        reset = 1;
        ioctl_download = 0;
        tick();
        reset = 0;
        exp_ovr = 0;
        exp_mod = 8'hFF;
        check("rst2_wait", 64'(ioctl_wait), 64'd0);
        check("rst2_hold", 64'(core_reset_hold), 64'd0);
        check("rst2_mod", 64'(mod), 64'hFF);
        check("rst2_dip", dip, 64'd0);
        check("rst2_ovr", 64'(overrun), 64'd0);
        tgt_ready = 1;
        repeat (5) tick();
        check("no_write_after_reset", 64'(seen), 64'(pushed));

        ioctl_download = 1;
        tick();
        tick();
        rom_byte(25'h16000, 8'hA5, 5, 1);
        rom_byte(25'h00042, 8'($urandom), 0, 0);
        hold_phase();
        repeat (4) tick();
        check("final_writes", 64'(seen), 64'(pushed));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
